// File: rtl/pwm_duty_decoder_pkg.sv
// rtl/pwm_duty_decoder_pkg.sv - shared constants and FSM encoding for the PWM duty decoder
//
// Purpose: definitions shared with the 100 kHz carrier generator.
//   CARRIER_PERIOD  nominal carrier period in clk cycles (50 MHz / 100 kHz)
//   CNT_W_DEF       default width of the period/high counters
//   state_e         decoder FSM encoding
package pwm_duty_decoder_pkg;

   localparam int CARRIER_PERIOD = 500;
   localparam int CNT_W_DEF      = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MEAS = 1'b1
   } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with registered rising-edge detect
//
// Purpose: brings an asynchronous level into the clk domain and flags its rising edges.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous, active-high reset (all stages clear to 0)
//   d_async  in  asynchronous input level
//   q_sync   out synchronized level (edge-register stage)
//   rise     out one-cycle pulse, q_sync went 0 -> 1; asserted 3 clk after d_async rises
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic q_sync,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic cur_q;
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         cur_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_async;
         sync_q <= meta_q;
         cur_q  <= sync_q;
         prev_q <= cur_q;
      end
   end

   assign q_sync = cur_q;
   assign rise   = cur_q & ~prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - measures period and high time of each PWM carrier cycle
//
// Purpose: samples an external PWM line and publishes (period, high) per complete carrier
//   cycle over a valid/ready handshake; flags carrier loss, glitches and dropped results.
// Ports:
//   clk           in   system clock (50 MHz)
//   rst           in   asynchronous, active-high reset
//   pwm_in        in   asynchronous PWM line
//   meas_ready    in   consumer accepts the measurement this cycle
//   clr_ovr       in   clears the overrun flag
//   period_out    out  cycles between consecutive rising edges
//   high_out      out  cycles pwm was high within that period
//   meas_valid    out  period_out/high_out valid; held until accepted
//   overrun       out  sticky: a measurement was dropped
//   glitch        out  one-cycle pulse: a too-short period was discarded
//   carrier_lost  out  level: no valid carrier
module pwm_duty_decoder
   import pwm_duty_decoder_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int TIMEOUT    = 2 * CARRIER_PERIOD,
   parameter int MIN_PERIOD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   input  logic             meas_ready,
   input  logic             clr_ovr,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             overrun,
   output logic             glitch,
   output logic             carrier_lost
);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_PERIOD);

   logic s_cur;
   logic rise;

   sync_edge_det u_sync_edge_det (
      .clk     (clk),
      .rst     (rst),
      .d_async (pwm_in),
      .q_sync  (s_cur),
      .rise    (rise)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0] period_out_q, period_out_d;
   logic [CNT_W-1:0] high_out_q, high_out_d;
   logic             meas_valid_q, meas_valid_d;
   logic             overrun_q, overrun_d;
   logic             glitch_q, glitch_d;
   logic             carrier_lost_q, carrier_lost_d;
   logic             publish;
   logic             timeout;

   // Next-state logic: FSM and counters.
   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
      publish      = 1'b0;
      glitch_d     = 1'b0;
      timeout      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The rise cycle itself is high, so both counters start at 1.
            if (rise) begin
               state_d      = ST_MEAS;
               period_cnt_d = CNT_ONE;
               high_cnt_d   = CNT_ONE;
            end
         end
         ST_MEAS: begin
            if (rise) begin
               if (period_cnt_q < MIN_CNT) begin
                  glitch_d = 1'b1;
               end else begin
                  publish = 1'b1;
               end
               period_cnt_d = CNT_ONE;
               high_cnt_d   = CNT_ONE;
            end else if (period_cnt_q == TIMEOUT_CNT) begin
               state_d      = ST_IDLE;
               period_cnt_d = '0;
               high_cnt_d   = '0;
               timeout      = 1'b1;
            end else begin
               period_cnt_d = period_cnt_q + CNT_ONE;
               high_cnt_d   = high_cnt_q + CNT_W'(s_cur);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output register, handshake and flags.
   always_comb begin
      period_out_d   = period_out_q;
      high_out_d     = high_out_q;
      meas_valid_d   = meas_valid_q;
      overrun_d      = overrun_q;
      carrier_lost_d = carrier_lost_q;

      if (meas_valid_q && meas_ready) begin
         meas_valid_d = 1'b0;
      end

      if (clr_ovr) begin
         overrun_d = 1'b0;
      end

      if (publish) begin
         carrier_lost_d = 1'b0;
         // A transfer in this same cycle frees the slot for the new pair.
         if (!meas_valid_q || meas_ready) begin
            period_out_d = period_cnt_q;
            high_out_d   = high_cnt_q;
            meas_valid_d = 1'b1;
         end else begin
            // Set wins over a simultaneous clr_ovr.
            overrun_d = 1'b1;
         end
      end

      if (timeout) begin
         carrier_lost_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         period_cnt_q   <= '0;
         high_cnt_q     <= '0;
         period_out_q   <= '0;
         high_out_q     <= '0;
         meas_valid_q   <= 1'b0;
         overrun_q      <= 1'b0;
         glitch_q       <= 1'b0;
         carrier_lost_q <= 1'b1;
      end else begin
         state_q        <= state_d;
         period_cnt_q   <= period_cnt_d;
         high_cnt_q     <= high_cnt_d;
         period_out_q   <= period_out_d;
         high_out_q     <= high_out_d;
         meas_valid_q   <= meas_valid_d;
         overrun_q      <= overrun_d;
         glitch_q       <= glitch_d;
         carrier_lost_q <= carrier_lost_d;
      end
   end

   assign period_out   = period_out_q;
   assign high_out     = high_out_q;
   assign meas_valid   = meas_valid_q;
   assign overrun      = overrun_q;
   assign glitch       = glitch_q;
   assign carrier_lost = carrier_lost_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - directed self-checking bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 1000;

   logic             clk;
   logic             rst;
   logic             pwm_in;
   logic             meas_ready;
   logic             clr_ovr;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             meas_valid;
   logic             overrun;
   logic             glitch;
   logic             carrier_lost;

   int checks;
   int errors;

   pwm_duty_decoder #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TIMEOUT),
      .MIN_PERIOD (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pwm_in       (pwm_in),
      .meas_ready   (meas_ready),
      .clr_ovr      (clr_ovr),
      .period_out   (period_out),
      .high_out     (high_out),
      .meas_valid   (meas_valid),
      .overrun      (overrun),
      .glitch       (glitch),
      .carrier_lost (carrier_lost)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int n);
      pwm_in = v;
      repeat (n) step();
   endtask

   // The third step after a pwm_in rise is the internal rise cycle; results show one step later.
   task automatic rise_wait();
      pwm_in = 1'b1;
      repeat (4) step();
   endtask

   task automatic check_pair(input string tag, input int p, input int h);
      check_val({tag, "_valid"}, 32'(meas_valid), 32'd1);
      check_val({tag, "_period"}, 32'(period_out), p);
      check_val({tag, "_high"}, 32'(high_out), h);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      pwm_in     = 1'b0;
      meas_ready = 1'b0;
      clr_ovr    = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      check_val("rst_valid", 32'(meas_valid), 32'd0);
      check_val("rst_period", 32'(period_out), 32'd0);
      check_val("rst_high", 32'(high_out), 32'd0);
      check_val("rst_overrun", 32'(overrun), 32'd0);
      check_val("rst_glitch", 32'(glitch), 32'd0);
      check_val("rst_lost", 32'(carrier_lost), 32'd1);

      // Nominal carrier 375/125: first rise only starts counting.
      drive(1'b1, 375);
      drive(1'b0, 125);
      check_val("t1_no_pub_valid", 32'(meas_valid), 32'd0);
      check_val("t1_no_pub_lost", 32'(carrier_lost), 32'd1);
      drive(1'b1, 375);
      check_pair("t1", 500, 375);
      check_val("t1_lost", 32'(carrier_lost), 32'd0);

      // Held ready low: 600/375 pair is dropped, first pair stays put.
      drive(1'b0, 225);
      drive(1'b1, 300);
      check_pair("t2_held", 500, 375);
      check_val("t2_overrun", 32'(overrun), 32'd1);
      clr_ovr = 1'b1;
      step();
      clr_ovr = 1'b0;
      check_val("t2_clr_overrun", 32'(overrun), 32'd0);
      check_val("t2_clr_valid", 32'(meas_valid), 32'd1);

      // Ready high only in the rise cycle: new pair (301 high + 100 low) replaces old.
      drive(1'b0, 100);
      pwm_in = 1'b1;
      repeat (3) step();
      meas_ready = 1'b1;
      step();
      meas_ready = 1'b0;
      check_pair("t6", 401, 301);
      check_val("t6_overrun", 32'(overrun), 32'd0);

      // Glitch: rise A, then a one-cycle pulse two cycles later.
      meas_ready = 1'b1;
      step();
      meas_ready = 1'b0;
      check_val("t3_accept_valid", 32'(meas_valid), 32'd0);
      drive(1'b1, 370);
      drive(1'b0, 125);
      drive(1'b1, 1);
      drive(1'b0, 1);
      rise_wait();
      check_val("t3_glitch", 32'(glitch), 32'd1);
      check_pair("t3_pubA", 500, 375);
      check_val("t3_overrun", 32'(overrun), 32'd0);
      step();
      check_val("t3_glitch_end", 32'(glitch), 32'd0);
      meas_ready = 1'b1;
      step();
      meas_ready = 1'b0;
      drive(1'b1, 369);
      drive(1'b0, 125);
      rise_wait();
      check_pair("t3_after_glitch", 500, 375);

      // Carrier stops high: loss exactly TIMEOUT cycles after the last rise.
      repeat (TIMEOUT - 1) step();
      check_val("t4_lost_early", 32'(carrier_lost), 32'd0);
      step();
      check_val("t4_lost", 32'(carrier_lost), 32'd1);
      meas_ready = 1'b1;
      step();
      meas_ready = 1'b0;
      check_val("t4_accept_valid", 32'(meas_valid), 32'd0);
      drive(1'b0, 125);
      drive(1'b1, 375);
      drive(1'b0, 125);
      check_val("t4_first_rise_valid", 32'(meas_valid), 32'd0);
      check_val("t4_first_rise_lost", 32'(carrier_lost), 32'd1);
      rise_wait();
      check_pair("t4_resume", 500, 375);
      check_val("t4_resume_lost", 32'(carrier_lost), 32'd0);

      // Reset mid-period with a result pending.
      drive(1'b1, 196);
      rst    = 1'b1;
      pwm_in = 1'b0;
      step();
      check_val("t5_valid", 32'(meas_valid), 32'd0);
      check_val("t5_period", 32'(period_out), 32'd0);
      check_val("t5_high", 32'(high_out), 32'd0);
      check_val("t5_lost", 32'(carrier_lost), 32'd1);
      check_val("t5_overrun", 32'(overrun), 32'd0);
      step();
      rst = 1'b0;
      drive(1'b0, 10);
      drive(1'b1, 375);
      drive(1'b0, 125);
      check_val("t5_first_rise_valid", 32'(meas_valid), 32'd0);
      rise_wait();
      check_pair("t5_second_rise", 500, 375);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
